// File: rtl/taillight_pattern_decoder.sv
// Receive-side decoder for the Thunderbird tail-light sequencer: rebuilds the active mode from the lamp lines.
// Optional macro TLD_ABORT_ERR_EN: when defined, an all-off step in the middle of a sequence counts as an error.
module taillight_pattern_decoder #(
  parameter int QUIET_STEPS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_en,
  input  logic [2:0]       lamps_l,
  input  logic [2:0]       lamps_r,
  output logic [1:0]       mode,
  output logic             mode_valid,
  output logic             cycle_done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HZ   = 3'd7
  } state_t;

  localparam logic [3:0] QS = 4'(QUIET_STEPS);

  state_t           r_state;
  logic [3:0]       r_quiet;
  logic [1:0]       r_mode;
  logic             r_mode_valid;
  logic             r_cycle_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_err_count;

  logic [5:0]       w_p;
  logic             w_off;
  logic             w_start;
  state_t           w_start_state;
  logic [1:0]       w_start_mode;
  logic [5:0]       w_exp_p;
  state_t           w_exp_next;
  logic             w_mid;
  logic             w_end;
  logic [3:0]       w_quiet_inc;
  logic [CNT_W-1:0] w_err_cnt_inc;

  assign w_p           = {lamps_l, lamps_r};
  assign w_off         = (w_p == 6'b000_000);
  assign w_quiet_inc   = (r_quiet >= QS) ? r_quiet : r_quiet + 4'd1;
  assign w_err_cnt_inc = (&r_err_count) ? r_err_count : r_err_count + 1'b1;

  always_comb begin
    w_start       = 1'b1;
    w_start_state = S_IDLE;
    w_start_mode  = 2'b00;
    case (w_p)
      6'b001_000: begin w_start_state = S_L1; w_start_mode = 2'b01; end
      6'b000_001: begin w_start_state = S_R1; w_start_mode = 2'b10; end
      6'b111_111: begin w_start_state = S_HZ; w_start_mode = 2'b11; end
      default:    w_start = 1'b0;
    endcase
  end

  // Mid-sequence states advance on one expected pattern; end states close on all-off.
  always_comb begin
    w_exp_p    = 6'b000_000;
    w_exp_next = S_IDLE;
    w_mid      = 1'b0;
    w_end      = 1'b0;
    case (r_state)
      S_L1: begin w_exp_p = 6'b011_000; w_exp_next = S_L2; w_mid = 1'b1; end
      S_L2: begin w_exp_p = 6'b111_000; w_exp_next = S_L3; w_mid = 1'b1; end
      S_R1: begin w_exp_p = 6'b000_011; w_exp_next = S_R2; w_mid = 1'b1; end
      S_R2: begin w_exp_p = 6'b000_111; w_exp_next = S_R3; w_mid = 1'b1; end
      S_L3, S_R3, S_HZ: w_end = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_quiet       <= 4'd0;
      r_mode        <= 2'b00;
      r_mode_valid  <= 1'b0;
      r_cycle_done  <= 1'b0;
      r_err         <= 1'b0;
      r_cycle_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_cycle_done <= 1'b0;
      r_err        <= 1'b0;
      if (step_en) begin
        if (r_state == S_IDLE && w_off) begin
          r_quiet <= w_quiet_inc;
          if (w_quiet_inc == QS) begin
            r_mode       <= 2'b00;
            r_mode_valid <= 1'b0;
          end
        end else if (w_mid && w_p == w_exp_p) begin
          r_state <= w_exp_next;
        end else if (w_end && w_off) begin
          r_state       <= S_IDLE;
          r_quiet       <= 4'd0;
          r_cycle_done  <= 1'b1;
          r_cycle_count <= r_cycle_count + 1'b1;
        end else if (w_mid && w_off) begin
          // Abort counts as the first quiet step so the timeout still lines up.
          r_state <= S_IDLE;
          r_quiet <= 4'd1;
`ifdef TLD_ABORT_ERR_EN
          r_err       <= 1'b1;
          r_err_count <= w_err_cnt_inc;
`endif
        end else if (w_start) begin
          if (r_state != S_IDLE) begin
            r_err       <= 1'b1;
            r_err_count <= w_err_cnt_inc;
          end
          r_state      <= w_start_state;
          r_quiet      <= 4'd0;
          r_mode       <= w_start_mode;
          r_mode_valid <= 1'b1;
        end else begin
          r_err       <= 1'b1;
          r_err_count <= w_err_cnt_inc;
          r_state     <= S_IDLE;
          r_quiet     <= 4'd0;
        end
      end
    end
  end

  assign mode        = r_mode;
  assign mode_valid  = r_mode_valid;
  assign cycle_done  = r_cycle_done;
  assign err         = r_err;
  assign cycle_count = r_cycle_count;
  assign err_count   = r_err_count;

endmodule
